// File: rtl/variable_node_serial.sv
// Serial non-binary LDPC variable node: accumulates prior plus DEG check messages,
// issues a hard-decision symbol, then streams one saturated extrinsic vector per edge.
module variable_node_serial #(
    parameter int INPUT_BIT       = 3,
    parameter int OUTPUT_BIT      = 3,
    parameter int VARIABLE_DEGREE = 4,
    parameter int FIELD           = 3,
    localparam int SYM_BIT  = $clog2(FIELD),
    localparam int EDGE_BIT = ($clog2(VARIABLE_DEGREE) > 1) ? $clog2(VARIABLE_DEGREE) : 1,
    localparam int ACC_BIT  = INPUT_BIT + $clog2(VARIABLE_DEGREE + 1) + 1
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic [FIELD*INPUT_BIT-1:0]    PRIOR_LLR,
    input  logic                          PRIOR_VALID,
    output logic                          PRIOR_READY,
    input  logic [FIELD*INPUT_BIT-1:0]    IN_LLR,
    input  logic                          IN_VALID,
    output logic                          IN_READY,
    output logic [FIELD*OUTPUT_BIT-1:0]   OUT_LLR,
    output logic [EDGE_BIT-1:0]           OUT_EDGE,
    output logic                          OUT_VALID,
    input  logic                          OUT_READY,
    output logic [SYM_BIT-1:0]            OUTPUT_SYMBOL,
    output logic                          SYMBOL_VALID
);

    typedef enum logic [1:0] {IDLE, ACCUM, DECIDE, EMIT} state_t;

    localparam logic [EDGE_BIT-1:0] LAST_EDGE = EDGE_BIT'(VARIABLE_DEGREE - 1);
    localparam logic signed [ACC_BIT:0] SAT_MAX = (ACC_BIT+1)'((1 << (OUTPUT_BIT-1)) - 1);
    localparam logic signed [ACC_BIT:0] SAT_MIN = (ACC_BIT+1)'(-(1 << (OUTPUT_BIT-1)));

    state_t                     state_q, state_d;
    logic [EDGE_BIT-1:0]        cnt_q, cnt_d;
    logic [SYM_BIT-1:0]         sym_q, sym_d;
    logic signed [ACC_BIT-1:0]  acc_q [FIELD];
    logic signed [ACC_BIT-1:0]  acc_d [FIELD];
    logic signed [ACC_BIT-1:0]  buf_q [VARIABLE_DEGREE][FIELD];
    logic signed [ACC_BIT-1:0]  buf_d [VARIABLE_DEGREE][FIELD];

    logic signed [OUTPUT_BIT-1:0] sat_s [FIELD];
    logic signed [OUTPUT_BIT-1:0] best_val;
    logic [SYM_BIT-1:0]           best_idx;
    logic signed [ACC_BIT:0]      diff;
    logic [FIELD*OUTPUT_BIT-1:0]  out_llr;

    function automatic logic signed [ACC_BIT-1:0] sext(input logic [INPUT_BIT-1:0] v);
        return {{(ACC_BIT-INPUT_BIT){v[INPUT_BIT-1]}}, v};
    endfunction

    function automatic logic [OUTPUT_BIT-1:0] sat(input logic signed [ACC_BIT:0] v);
        if (v > SAT_MAX)      return SAT_MAX[OUTPUT_BIT-1:0];
        else if (v < SAT_MIN) return SAT_MIN[OUTPUT_BIT-1:0];
        else                  return v[OUTPUT_BIT-1:0];
    endfunction

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            sym_q   <= '0;
            for (int k = 0; k < FIELD; k++) begin
                acc_q[k] <= '0;
                for (int e = 0; e < VARIABLE_DEGREE; e++) buf_q[e][k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sym_q   <= sym_d;
            acc_q   <= acc_d;
            buf_q   <= buf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sym_d   = sym_q;
        acc_d   = acc_q;
        buf_d   = buf_q;
        case (state_q)
            IDLE: begin
                if (PRIOR_VALID) begin
                    for (int k = 0; k < FIELD; k++)
                        acc_d[k] = sext(PRIOR_LLR[k*INPUT_BIT +: INPUT_BIT]);
                    cnt_d   = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (IN_VALID) begin
                    for (int k = 0; k < FIELD; k++) begin
                        buf_d[cnt_q][k] = sext(IN_LLR[k*INPUT_BIT +: INPUT_BIT]);
                        acc_d[k] = acc_q[k] + sext(IN_LLR[k*INPUT_BIT +: INPUT_BIT]);
                    end
                    if (cnt_q == LAST_EDGE) begin
                        cnt_d   = '0;
                        state_d = DECIDE;
                    end else begin
                        cnt_d = cnt_q + EDGE_BIT'(1);
                    end
                end
            end
            DECIDE: begin
                sym_d   = best_idx;
                state_d = EMIT;
            end
            EMIT: begin
                if (OUT_READY) begin
                    if (cnt_q == LAST_EDGE) begin
                        cnt_d   = '0;
                        state_d = IDLE;
                    end else begin
                        cnt_d = cnt_q + EDGE_BIT'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strict '>' keeps the lowest index on ties.
    always_comb begin
        for (int k = 0; k < FIELD; k++)
            sat_s[k] = sat({acc_q[k][ACC_BIT-1], acc_q[k]});
        best_val = sat_s[0];
        best_idx = '0;
        for (int k = 1; k < FIELD; k++) begin
            if (sat_s[k] > best_val) begin
                best_val = sat_s[k];
                best_idx = SYM_BIT'(k);
            end
        end
    end

    always_comb begin
        out_llr = '0;
        diff    = '0;
        if (state_q == EMIT) begin
            for (int k = 0; k < FIELD; k++) begin
                diff = {acc_q[k][ACC_BIT-1], acc_q[k]}
                     - {buf_q[cnt_q][k][ACC_BIT-1], buf_q[cnt_q][k]};
                out_llr[k*OUTPUT_BIT +: OUTPUT_BIT] = sat(diff);
            end
        end
    end

    assign PRIOR_READY   = (state_q == IDLE);
    assign IN_READY      = (state_q == ACCUM);
    assign OUT_VALID     = (state_q == EMIT);
    assign SYMBOL_VALID  = (state_q == DECIDE);
    assign OUT_LLR       = out_llr;
    assign OUT_EDGE      = (state_q == EMIT) ? cnt_q : '0;
    assign OUTPUT_SYMBOL = (state_q == DECIDE) ? best_idx : sym_q;

endmodule

// File: tb/tb_variable_node_serial.sv
// Directed self-checking bench for variable_node_serial at default parameters.
module tb_variable_node_serial;

    localparam int DEG = 4;

    logic       CLK = 1'b0;
    logic       RST;
    logic [8:0] PRIOR_LLR, IN_LLR, OUT_LLR;
    logic       PRIOR_VALID, PRIOR_READY, IN_VALID, IN_READY;
    logic [1:0] OUT_EDGE, OUTPUT_SYMBOL;
    logic       OUT_VALID, OUT_READY, SYMBOL_VALID;

    int total = 0;
    int bad   = 0;

    logic [8:0] obs_llr  [DEG];
    logic [1:0] obs_edge [DEG];
    logic [1:0] obs_sym;
    int  n_out, sym_pulses, sym_cyc, first_out_cyc, idle_cyc, stall_seen;
    bit  timeout, stall_unstable, idle_ready, idle_out_valid;

    variable_node_serial dut (
        .CLK(CLK), .RST(RST),
        .PRIOR_LLR(PRIOR_LLR), .PRIOR_VALID(PRIOR_VALID), .PRIOR_READY(PRIOR_READY),
        .IN_LLR(IN_LLR), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
        .OUT_LLR(OUT_LLR), .OUT_EDGE(OUT_EDGE), .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
        .OUTPUT_SYMBOL(OUTPUT_SYMBOL), .SYMBOL_VALID(SYMBOL_VALID)
    );

    always #5 CLK = ~CLK;

    function automatic logic [8:0] vec(input int e0, input int e1, input int e2);
        return {3'(e2), 3'(e1), 3'(e0)};
    endfunction

    task automatic idle_inputs();
        PRIOR_VALID = 1'b0;
        IN_VALID    = 1'b0;
        OUT_READY   = 1'b1;
        PRIOR_LLR   = '0;
        IN_LLR      = '0;
    endtask

    // Drives one frame cycle by cycle on the falling edge; cycle 0 is the prior handshake.
    task automatic run_frame(input logic [8:0] prior, input logic [8:0] msg, input bit gaps,
                             input int bp_edge, input int bp_cycles, input bit spam,
                             input int stop_after_msgs);
        bit prior_sent = 0;
        bit holding = 0;
        int msgs = 0, c = -1, slot = 0, bp_left = bp_cycles;
        logic [8:0] hold_llr = '0;
        logic [1:0] hold_edge = '0;
        n_out = 0; sym_pulses = 0; sym_cyc = -1; first_out_cyc = -1; idle_cyc = -1;
        stall_seen = 0; timeout = 1; stall_unstable = 0; obs_sym = '0;
        idle_ready = 0; idle_out_valid = 0;
        for (int i = 0; i < DEG; i++) begin obs_llr[i] = 'x; obs_edge[i] = 'x; end
        for (int cyc = 0; cyc < 200; cyc++) begin
            @(negedge CLK);
            if (c >= 0) c++;
            if (SYMBOL_VALID) begin sym_pulses++; obs_sym = OUTPUT_SYMBOL; sym_cyc = c; end
            if (n_out >= DEG) begin
                idle_ready = PRIOR_READY; idle_out_valid = OUT_VALID; idle_cyc = c;
                timeout = 0; idle_inputs(); return;
            end
            if (stop_after_msgs >= 0 && msgs == stop_after_msgs) begin
                timeout = 0; idle_inputs(); return;
            end
            idle_inputs();
            if (!prior_sent) begin
                PRIOR_VALID = 1'b1; PRIOR_LLR = prior;
                if (PRIOR_READY) begin prior_sent = 1; c = 0; end
            end else if (msgs < DEG) begin
                if (spam) begin PRIOR_VALID = slot[0]; PRIOR_LLR = vec(3, -4, 3); end
                IN_VALID = gaps ? (slot % 3 == 0) : 1'b1;
                IN_LLR   = msg;
                slot++;
                if (IN_VALID && IN_READY) msgs++;
            end
            if (OUT_VALID) begin
                if (int'(OUT_EDGE) == bp_edge && bp_left > 0) begin
                    OUT_READY = 1'b0;
                    if (!holding) begin hold_llr = OUT_LLR; hold_edge = OUT_EDGE; holding = 1; end
                    else if (OUT_LLR !== hold_llr || OUT_EDGE !== hold_edge) stall_unstable = 1;
                    bp_left--; stall_seen++;
                end else begin
                    if (holding && (OUT_LLR !== hold_llr || OUT_EDGE !== hold_edge)) stall_unstable = 1;
                    holding = 0;
                    if (n_out == 0) first_out_cyc = c;
                    if (n_out < DEG) begin obs_llr[n_out] = OUT_LLR; obs_edge[n_out] = OUT_EDGE; end
                    n_out++;
                end
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset();
        RST = 1'b0;
        idle_inputs();
        repeat (3) @(negedge CLK);
        total++; if (PRIOR_READY !== 1'b1) begin bad++; $display("FAIL reset_prior_ready got=%b exp=1", PRIOR_READY); end
        total++; if (IN_READY !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", IN_READY); end
        total++; if (OUT_VALID !== 1'b0 || SYMBOL_VALID !== 1'b0) begin bad++; $display("FAIL reset_valids got=%b%b exp=00", OUT_VALID, SYMBOL_VALID); end
        total++; if (OUT_LLR !== 9'h0 || OUT_EDGE !== 2'd0 || OUTPUT_SYMBOL !== 2'd0) begin bad++; $display("FAIL reset_data got llr=%h edge=%0d sym=%0d exp=0", OUT_LLR, OUT_EDGE, OUTPUT_SYMBOL); end
        RST = 1'b1;
        @(negedge CLK);
    endtask

    task automatic test_nominal();
        run_frame(vec(0, 1, 0), vec(0, 0, 1), 0, -1, 0, 0, -1);
        total++; if (timeout) begin bad++; $display("FAIL nominal_timeout got=1 exp=0"); end
        total++; if (sym_pulses != 1) begin bad++; $display("FAIL nominal_pulses got=%0d exp=1", sym_pulses); end
        total++; if (obs_sym !== 2'd2) begin bad++; $display("FAIL nominal_symbol got=%0d exp=2", obs_sym); end
        total++; if (sym_cyc != DEG + 1) begin bad++; $display("FAIL nominal_decide_cycle got=%0d exp=%0d", sym_cyc, DEG + 1); end
        total++; if (first_out_cyc != DEG + 2) begin bad++; $display("FAIL nominal_first_out got=%0d exp=%0d", first_out_cyc, DEG + 2); end
        total++; if (idle_cyc != 2 * DEG + 2 || !idle_ready || idle_out_valid) begin bad++; $display("FAIL nominal_back_idle got cyc=%0d rdy=%b ov=%b exp cyc=%0d rdy=1 ov=0", idle_cyc, idle_ready, idle_out_valid, 2 * DEG + 2); end
        for (int i = 0; i < DEG; i++) begin
            total++; if (obs_llr[i] !== vec(0, 1, 3)) begin bad++; $display("FAIL nominal_llr%0d got=%h exp=%h", i, obs_llr[i], vec(0, 1, 3)); end
            total++; if (obs_edge[i] !== 2'(i)) begin bad++; $display("FAIL nominal_edge%0d got=%0d exp=%0d", i, obs_edge[i], i); end
        end
        total++; if (OUTPUT_SYMBOL !== 2'd2 || SYMBOL_VALID !== 1'b0) begin bad++; $display("FAIL nominal_symbol_hold got=%0d/%b exp=2/0", OUTPUT_SYMBOL, SYMBOL_VALID); end
    endtask

    task automatic test_saturation();
        run_frame(vec(3, 0, -4), vec(3, 0, -4), 0, -1, 0, 0, -1);
        total++; if (timeout) begin bad++; $display("FAIL sat_timeout got=1 exp=0"); end
        total++; if (obs_sym !== 2'd0 || sym_pulses != 1) begin bad++; $display("FAIL sat_symbol got=%0d pulses=%0d exp=0 pulses=1", obs_sym, sym_pulses); end
        for (int i = 0; i < DEG; i++) begin
            total++; if (obs_llr[i] !== vec(3, 0, -4)) begin bad++; $display("FAIL sat_llr%0d got=%h exp=%h", i, obs_llr[i], vec(3, 0, -4)); end
        end
    endtask

    task automatic test_ties();
        run_frame(vec(1, 1, 1), vec(0, 0, 0), 0, -1, 0, 0, -1);
        total++; if (timeout || obs_sym !== 2'd0) begin bad++; $display("FAIL tie_all_symbol got=%0d exp=0", obs_sym); end
        total++; if (obs_llr[3] !== vec(1, 1, 1)) begin bad++; $display("FAIL tie_all_llr got=%h exp=%h", obs_llr[3], vec(1, 1, 1)); end
        run_frame(vec(0, 2, 2), vec(0, 0, 0), 0, -1, 0, 0, -1);
        total++; if (timeout || obs_sym !== 2'd1) begin bad++; $display("FAIL tie_upper_symbol got=%0d exp=1", obs_sym); end
        total++; if (obs_llr[0] !== vec(0, 2, 2)) begin bad++; $display("FAIL tie_upper_llr got=%h exp=%h", obs_llr[0], vec(0, 2, 2)); end
    endtask

    task automatic test_backpressure();
        run_frame(vec(0, 1, 0), vec(0, 0, 1), 0, 1, 3, 0, -1);
        total++; if (timeout) begin bad++; $display("FAIL bp_timeout got=1 exp=0"); end
        total++; if (stall_seen != 3 || stall_unstable) begin bad++; $display("FAIL bp_stall got stalls=%0d unstable=%b exp stalls=3 unstable=0", stall_seen, stall_unstable); end
        total++; if (idle_cyc != 2 * DEG + 5 || !idle_ready) begin bad++; $display("FAIL bp_idle got cyc=%0d rdy=%b exp cyc=%0d rdy=1", idle_cyc, idle_ready, 2 * DEG + 5); end
        for (int i = 0; i < DEG; i++) begin
            total++; if (obs_edge[i] !== 2'(i) || obs_llr[i] !== vec(0, 1, 3)) begin bad++; $display("FAIL bp_out%0d got edge=%0d llr=%h exp edge=%0d llr=%h", i, obs_edge[i], obs_llr[i], i, vec(0, 1, 3)); end
        end
    endtask

    task automatic test_input_gaps();
        run_frame(vec(0, 1, 0), vec(0, 0, 1), 1, -1, 0, 1, -1);
        total++; if (timeout) begin bad++; $display("FAIL gaps_timeout got=1 exp=0"); end
        total++; if (obs_sym !== 2'd2 || sym_pulses != 1) begin bad++; $display("FAIL gaps_symbol got=%0d pulses=%0d exp=2 pulses=1", obs_sym, sym_pulses); end
        total++; if (sym_cyc != 3 * (DEG - 1) + 2) begin bad++; $display("FAIL gaps_decide_cycle got=%0d exp=%0d", sym_cyc, 3 * (DEG - 1) + 2); end
        for (int i = 0; i < DEG; i++) begin
            total++; if (obs_edge[i] !== 2'(i) || obs_llr[i] !== vec(0, 1, 3)) begin bad++; $display("FAIL gaps_out%0d got edge=%0d llr=%h exp edge=%0d llr=%h", i, obs_edge[i], obs_llr[i], i, vec(0, 1, 3)); end
        end
    endtask

    task automatic test_reset_mid_accum();
        run_frame(vec(3, 3, -4), vec(-4, 3, 3), 0, -1, 0, 0, 2);
        total++; if (timeout || IN_READY !== 1'b1) begin bad++; $display("FAIL midrst_pre got in_ready=%b exp=1", IN_READY); end
        #2 RST = 1'b0;
        #1;
        total++; if (PRIOR_READY !== 1'b1 || IN_READY !== 1'b0) begin bad++; $display("FAIL midrst_ready got=%b%b exp=10", PRIOR_READY, IN_READY); end
        total++; if (OUT_VALID !== 1'b0 || SYMBOL_VALID !== 1'b0 || OUT_LLR !== 9'h0 || OUT_EDGE !== 2'd0 || OUTPUT_SYMBOL !== 2'd0) begin bad++; $display("FAIL midrst_outputs got ov=%b sv=%b llr=%h edge=%0d sym=%0d exp all 0", OUT_VALID, SYMBOL_VALID, OUT_LLR, OUT_EDGE, OUTPUT_SYMBOL); end
        @(negedge CLK);
        RST = 1'b1;
        run_frame(vec(0, 1, 0), vec(0, 0, 1), 0, -1, 0, 0, -1);
        total++; if (timeout || obs_sym !== 2'd2 || sym_pulses != 1) begin bad++; $display("FAIL midrst_symbol got=%0d pulses=%0d exp=2 pulses=1", obs_sym, sym_pulses); end
        for (int i = 0; i < DEG; i++) begin
            total++; if (obs_edge[i] !== 2'(i) || obs_llr[i] !== vec(0, 1, 3)) begin bad++; $display("FAIL midrst_out%0d got edge=%0d llr=%h exp edge=%0d llr=%h", i, obs_edge[i], obs_llr[i], i, vec(0, 1, 3)); end
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_saturation();
        test_ties();
        test_backpressure();
        test_input_gaps();
        test_reset_mid_accum();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
